// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr slice: mode encodings and the
// packet-lock state type.
package stream_mux_rr_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin search. Grants the first requesting
// channel strictly after ptr, wrapping CHANNELS-1 -> 0. The parent owns ptr.
module rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  logic [SEL_W-1:0] idx;

  // Scan offsets 1..CHANNELS from ptr; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      idx = SEL_W'((32'(ptr) + off) % CHANNELS);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with a one-entry registered
// output, per-beat round-robin or manual channel selection.
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and
// holds the grant on one channel until its last beat is accepted.
module stream_mux_rr #(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  import stream_mux_rr_pkg::*;

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
  logic [SEL_W-1:0]    ptr_q,       ptr_d;

  logic                load_en;
  logic [CHANNELS-1:0] arb_grant;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gidx;
  logic [WIDTH-1:0]    beat_data;
  logic                beat_last;
  logic                accept;
  logic                locked;
  logic [SEL_W-1:0]    lock_chan;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign load_en = !out_valid_q || out_ready;

  // Grant source: an active packet lock overrides mode; manual uses sel, otherwise RR.
  always_comb begin
    grant = '0;
    gidx  = '0;
    if (locked) begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        grant[i] = in_valid[i] && (32'(lock_chan) == i);
      gidx = lock_chan;
    end else if (mode == MODE_MANUAL) begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        grant[i] = in_valid[i] && (32'(sel) == i);
      gidx = sel;
    end else if (arb_any) begin
      grant = arb_grant;
      gidx  = arb_idx;
    end
  end

  // Handshake and selected beat; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = (rst_n && load_en) ? grant : '0;
    accept    = |(in_valid & in_ready);
    beat_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      if (grant[i]) beat_data = beat_data | in_data[i*WIDTH +: WIDTH];
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_e            lock_q,      lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
  logic             out_last_q,  out_last_d;

  assign beat_last = |(in_last & grant);
  assign locked    = (lock_q == LOCK_HELD);
  assign lock_chan = lock_chan_q;
  assign out_last  = out_last_q;

  // Lock tracking: a non-last beat locks its channel, a last beat releases it.
  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    out_last_d  = out_last_q;
    if (accept) begin
      lock_d      = beat_last ? LOCK_IDLE : LOCK_HELD;
      lock_chan_d = gidx;
      out_last_d  = beat_last;
    end
  end

  // Lock state and out_last registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= LOCK_IDLE;
      lock_chan_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      out_last_q  <= out_last_d;
    end
  end
`else
  assign beat_last = 1'b1;
  assign locked    = 1'b0;
  assign lock_chan = '0;
`endif

  // Output stage next state: load on accept, clear valid on drain, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = beat_data;
      out_valid_d = 1'b1;
      out_chan_d  = gidx;
      if (mode == MODE_RR && beat_last) ptr_d = gidx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and RR pointer; ptr resets so that channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (WIDTH=4, CHANNELS=4).
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int unsigned checks;
  int unsigned errors;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".chan"},  32'(out_chan),  32'(ch));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  int unsigned rr_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_data   = 16'h4321;
    in_valid  = 4'hF;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last   = 4'hF;
`endif

    // Reset state
    tick(); tick();
    chk_out("rst", 1'b0, 2'd0, 4'h0);
    chk("rst.in_ready", 32'(in_ready), 32'h0);

    // Release: ptr=3 so channel 0 is granted first
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'h1);

    // RR fairness with all channels valid
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, 2'(rr_seq[k]), 4'(rr_seq[k] + 1));
      chk($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(1) << ((rr_seq[k] + 1) % 4));
    end

    // Skip and wrap: ptr=0, only ch0 and ch3 valid -> 3,0,3
    in_valid = 4'b1001;
    #1;
    chk("wrap.in_ready", 32'(in_ready), 32'h8);
    tick(); chk_out("wrap0", 1'b1, 2'd3, 4'h4);
    tick(); chk_out("wrap1", 1'b1, 2'd0, 4'h1);
    tick(); chk_out("wrap2", 1'b1, 2'd3, 4'h4);

    // Backpressure: held beat stays, no in_ready, new input data ignored
    out_ready = 1'b0;
    in_data   = 16'h8765;
    in_valid  = 4'hF;
    #1;
    chk("bp.in_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 2'd3, 4'h4);
      chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bprel.in_ready", 32'(in_ready), 32'h1);
    tick(); chk_out("bprel", 1'b1, 2'd0, 4'h5);

    // Drain with no load: valid drops, data/chan hold
    in_valid = 4'h0;
    #1;
    chk("drain.in_ready", 32'(in_ready), 32'h0);
    tick(); chk_out("drain", 1'b0, 2'd0, 4'h5);

    // Manual select of ch2
    mode     = 1'b1;
    sel      = 2'd2;
    in_data  = 16'h4A21;
    in_valid = 4'hF;
    #1;
    chk("man.in_ready", 32'(in_ready), 32'h4);
    tick(); chk_out("man", 1'b1, 2'd2, 4'hA);
    in_valid = 4'b1011;
    #1;
    chk("man_nv.in_ready", 32'(in_ready), 32'h0);
    tick(); chk_out("man_nv", 1'b0, 2'd2, 4'hA);

    // Back to RR: manual beats left ptr at 0, so ch1 is next
    mode     = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("rrback.in_ready", 32'(in_ready), 32'h2);
    tick(); chk_out("rrback", 1'b1, 2'd1, 4'h2);

    // Reset mid-stream clears output immediately and blocks in_ready
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 2'd0, 4'h0);
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrel.in_ready", 32'(in_ready), 32'h1);
    tick(); chk_out("midrel", 1'b1, 2'd0, 4'h1);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // ptr=0: ch1 sends a 3-beat packet while ch0 stays valid
    in_valid = 4'b0011;
    in_last  = 4'b0001;
    tick(); chk_out("lk1", 1'b1, 2'd1, 4'h2);
    chk("lk1.last", 32'(out_last), 32'h0);
    tick(); chk_out("lk2", 1'b1, 2'd1, 4'h2);
    chk("lk2.last", 32'(out_last), 32'h0);
    in_last = 4'b0011;
    tick(); chk_out("lk3", 1'b1, 2'd1, 4'h2);
    chk("lk3.last", 32'(out_last), 32'h1);
    tick(); chk_out("lk4", 1'b1, 2'd0, 4'h1);
    chk("lk4.last", 32'(out_last), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
